// File: rtl/tx_arbiter.sv
// Arbiter in front of a serial byte transmitter that has no busy flag.
// Round-robin by default; define TX_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int FRAME_CYCLES = 12,
    parameter int IDW          = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     ack,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy,
    output logic                 send,
    output logic [7:0]           data
);

    localparam int CW = $clog2(FRAME_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [N_REQ-1:0] ack_q;
    logic [IDW-1:0]   grant_q;
    logic             busy_q;
    logic             send_q;
    logic [7:0]       data_q;

    logic [IDW-1:0]   win_d;
    logic             hit_d;
    logic [7:0]       byte_d;

`ifdef TX_ARB_FIXED_PRIO_EN
    always_comb begin
        win_d = '0;
        hit_d = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_d = IDW'(i);
                hit_d = 1'b1;
            end
        end
    end
`else
    logic [IDW-1:0] rr_q;
    logic [IDW:0]   idx;

    // Descending scan so the closest set bit at or after rr wins last.
    always_comb begin
        win_d = '0;
        hit_d = 1'b0;
        idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_q} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(N_REQ))
                idx = idx - (IDW+1)'(N_REQ);
            if (req[idx[IDW-1:0]]) begin
                win_d = idx[IDW-1:0];
                hit_d = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        byte_d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_d == IDW'(i))
                byte_d = req_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            send_q  <= 1'b0;
            data_q  <= 8'h00;
`ifndef TX_ARB_FIXED_PRIO_EN
            rr_q    <= '0;
`endif
        end else begin
            send_q <= 1'b0;
            ack_q  <= '0;
            unique case (state_q)
                IDLE: begin
                    if (hit_d) begin
                        ack_q   <= N_REQ'(1) << win_d;
                        grant_q <= win_d;
                        data_q  <= byte_d;
                        busy_q  <= 1'b1;
                        state_q <= SEND;
`ifndef TX_ARB_FIXED_PRIO_EN
                        rr_q    <= (win_d == IDW'(N_REQ - 1)) ?
                                   '0 : win_d + IDW'(1);
`endif
                    end
                end
                SEND: begin
                    send_q  <= 1'b1;
                    cnt_q   <= CW'(FRAME_CYCLES - 1);
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack      = ack_q;
    assign grant_id = grant_q;
    assign busy     = busy_q;
    assign send     = send_q;
    assign data     = data_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter with a frame-timing reference model.
// Build with TX_ARB_FIXED_PRIO_EN defined to exercise fixed priority.
module tb_tx_arbiter;

    localparam int N   = 4;
    localparam int FC  = 12;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [8*N-1:0]  req_data;
    logic [N-1:0]    ack;
    logic [IDW-1:0]  grant_id;
    logic            busy;
    logic            send;
    logic [7:0]      data;

    tx_arbiter #(.N_REQ(N), .FRAME_CYCLES(FC), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .ack(ack), .grant_id(grant_id), .busy(busy),
        .send(send), .data(data)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int sendq[$];
    logic [7:0] bytes [N];

    // Reference model: frames are timed by edges elapsed since the grant.
    bit         started = 0;
    int         m_d;
    int         m_rr;
    logic [N-1:0]   m_ack;
    logic [IDW-1:0] m_gid;
    logic       m_busy, m_send;
    logic [7:0] m_data;

    always @(posedge clk) begin
        int w;
        cyc++;
        if (!rst) begin
            started = 1;
            m_d = FC + 2; m_rr = 0;
            m_ack = '0; m_gid = '0; m_busy = 0; m_send = 0; m_data = 8'h00;
        end else if (started) begin
            if (m_d < 1000) m_d++;
            m_ack = '0;
            if (m_d >= FC + 2 && req != '0) begin
                w = -1;
`ifdef TX_ARB_FIXED_PRIO_EN
                for (int i = 0; i < N; i++)
                    if (w < 0 && req[i]) w = i;
`else
                for (int k = 0; k < N; k++)
                    if (w < 0 && req[(m_rr + k) % N]) w = (m_rr + k) % N;
                m_rr = (w + 1) % N;
`endif
                m_d = 0;
                m_ack = '0;
                m_ack[w] = 1'b1;
                m_gid = IDW'(w);
                m_data = bytes[w];
            end
            m_send = (m_d == 1);
            m_busy = (m_d <= FC);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            nvec++;
            if ({ack, grant_id, busy, send, data} !==
                {m_ack, m_gid, m_busy, m_send, m_data}) begin
                nerr++;
                $display("FAIL model cyc=%0d: ack=%b gid=%0d busy=%b send=%b data=%h, required ack=%b gid=%0d busy=%b send=%b data=%h",
                         cyc, ack, grant_id, busy, send, data,
                         m_ack, m_gid, m_busy, m_send, m_data);
            end
        end
        if (send === 1'b1) sendq.push_back(cyc);
    end

    task automatic chk(input string nm, input int got, input int exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d required %0d", nm, got, exp);
        end
    endtask

    task automatic next_grant(input string nm, output int id, output int b, output int t);
        int n;
        n = 0;
        id = -1; b = -1; t = -1;
        @(negedge clk);
        while (ack == '0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (ack == '0) begin
            nvec++; nerr++;
            $display("FAIL %s: no ack within 60 cycles, required one", nm);
        end else begin
            id = int'(grant_id); b = int'(data); t = cyc;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_send", send, 0);
        chk("rst_ack", ack, 0);
        chk("rst_data", data, 0);
        chk("rst_gid", grant_id, 0);
        rst = 1'b1;
    endtask

    initial begin
        int id, b, t, tprev, nb;
        int exp_order[$];
        int got_order[$];
        bytes[0] = 8'h3C; bytes[1] = 8'h5A; bytes[2] = 8'hA5; bytes[3] = 8'hC3;
        req_data = {bytes[3], bytes[2], bytes[1], bytes[0]};
        rst = 1'b0;
        req = '0;
        do_reset();

        // single request
        req = 4'b0100;
        next_grant("single", id, b, t);
        chk("single_ack", ack, 4'b0100);
        chk("single_gid", id, 2);
        chk("single_data", b, 8'hA5);
        chk("single_send_early", send, 0);
        req = '0;
        @(negedge clk);
        chk("single_send", send, 1);
        nb = 2;
        while (busy && nb < 40) begin
            @(negedge clk);
            if (busy) nb++;
        end
        chk("single_busy_len", nb, 13);

        // round robin, everyone requesting
        do_reset();
        sendq.delete();
        req = 4'b1111;
        got_order.delete();
        for (int g = 0; g < 4; g++) begin
            next_grant("rr_all", id, b, t);
            got_order.push_back(id);
            if (id >= 0) begin
                chk("rr_all_data", b, bytes[id]);
                req[id] = 1'b0;
            end
        end
        for (int g = 0; g < 4; g++)
            chk("rr_all_order", (g < got_order.size()) ? got_order[g] : -1, g);
        repeat (2) @(negedge clk);
        chk("rr_send_count", sendq.size(), 4);
        if (sendq.size() >= 4)
            for (int i = 1; i < 4; i++)
                chk("rr_send_gap", sendq[i] - sendq[i-1], 14);

        // wrap: rr is back at 0 after granting 3
        req = 4'b1001;
        next_grant("wrap_a", id, b, t);
        chk("wrap_first", id, 0);
        req[0] = 1'b0;
        next_grant("wrap_b", id, b, t);
        chk("wrap_second", id, 3);
        req[3] = 1'b0;

`ifndef TX_ARB_FIXED_PRIO_EN
        // held request, then a late competitor
        req = 4'b0010;
        next_grant("held0", id, b, tprev);
        chk("held_id0", id, 1);
        for (int g = 0; g < 2; g++) begin
            next_grant("held", id, b, t);
            chk("held_id", id, 1);
            chk("held_gap", t - tprev, 14);
            tprev = t;
        end
        req[2] = 1'b1;
        next_grant("held_c", id, b, t);
        chk("held_comp", id, 2);
        chk("held_comp_data", b, 8'hA5);
        req[2] = 1'b0;
        next_grant("held_back", id, b, t);
        chk("held_back", id, 1);
        req = '0;
`else
        // fixed priority: 1 starves 3 while held
        do_reset();
        req = 4'b1010;
        for (int g = 0; g < 3; g++) begin
            next_grant("fix", id, b, t);
            chk("fix_id", id, 1);
        end
        req[1] = 1'b0;
        next_grant("fix_3", id, b, t);
        chk("fix_starved", id, 3);
        req = '0;
`endif

        // reset in the middle of WAIT with a pending request
        nb = 0;
        while (busy && nb < 40) begin
            @(negedge clk);
            nb++;
        end
        req = 4'b0001;
        next_grant("mid", id, b, t);
        chk("mid_id", id, 0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_busy", busy, 0);
        chk("mid_send", send, 0);
        chk("mid_data", data, 0);
        chk("mid_gid", grant_id, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_regrant", ack, 4'b0001);
        chk("mid_regrant_data", data, 8'h3C);
        req = '0;
        @(negedge clk);
        chk("mid_regrant_send", send, 1);
        repeat (16) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/tx_arbiter.md
# tx_arbiter

Round-robin arbiter sharing one 8-bit serial transmitter (`fsm`: `send`/`data` in, `txd` out) among `N_REQ` byte producers. The transmitter has no busy output, so this block grants one requester per frame and times the frame internally. It drives the transmitter's `send` and `data` pins and sits directly in front of the transmitter.

## Interface
- `N_REQ`, default 4: number of requesters. Legal range 2..8.
- `FRAME_CYCLES`, default 12: length of the post-send wait in clk cycles. Must be >= 11: edge detect + start + 8 data + stop.
- `IDW`, default `$clog2(N_REQ)`: width of `grant_id`.
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: synchronous, active-low reset. Sampled on posedge clk; `rst`=0 resets.
- `req` in N_REQ: level request per requester. Held until the matching `ack`.
- `req_data` in 8*N_REQ: byte for requester i at bits [8i+7:8i]. Stable while `req[i]`=1.
- `ack` out N_REQ: one-hot, one-cycle pulse when the winner's byte is captured.
- `grant_id` out IDW: index of the current or last winner.
- `busy` out 1: high in any state other than IDLE.
- `send` out 1: to transmitter `send`. Exactly one-cycle high pulse per frame.
- `data` out 8: to transmitter `data`. Captured byte, held until the next capture.

## Operation
- States:
  - IDLE: if `req`!=0, pick the winner, capture its byte into `data`, pulse `ack[winner]`, set `grant_id`, go to SEND. Otherwise stay in IDLE.
  - SEND: `send`=1, load counter = FRAME_CYCLES-1, go to WAIT.
  - WAIT: `send`=0, decrement counter. At 0 go to IDLE.
- Round-robin:
  - Pointer `rr` (IDW bits, reset 0).
  - The winner is the first set `req` bit searching rr, rr+1, ... with modulo-N_REQ wrap.
  - On grant, `rr` <= winner+1, wrapping from N_REQ-1 to 0.
- All outputs are registered. `ack`, `data` and `grant_id` update on the same edge.
- `req` is sampled only in IDLE. Requests raised during SEND or WAIT wait for the next IDLE.
- A requester that keeps `req` high after `ack` is treated as requesting another frame. It competes normally, so it is served again only after the other active requesters.
- If `req[i]` drops before being sampled in IDLE, no grant is made to i.
- Bits of `req` at index >= N_REQ do not exist. Widths are exact.
- Reset (`rst`=0 at an edge, including mid-SEND or mid-WAIT):
  - Values: `send`=0, `ack`=0, `busy`=0, `data`=8'h00, `grant_id`=0, `rr`=0, counter=0, state=IDLE.
  - Any in-progress frame is abandoned.
  - Resetting the transmitter is the system's job, not this block's.

## Timing
- `req` high at edge E while in IDLE:
  - `ack`, `data` and `grant_id` are valid after E.
  - `send` is high after E+1 for exactly one cycle.
- `busy` rises after E and falls after E+1+FRAME_CYCLES.
- Back-to-back pending requests: consecutive `send` rising edges are exactly FRAME_CYCLES+2 cycles apart (14 by default).
- `send` is low for at least FRAME_CYCLES+1 cycles between pulses. This guarantees the transmitter's rising-edge detector re-arms.
- `data` does not change from capture until at least FRAME_CYCLES+1 cycles after `send`. This covers all 8 serialized bits.

## Configuration
- `TX_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins. `rr` is not implemented, and `grant_id` alone records the winner.
  - Undefined (default): round-robin as described above.
- All timing is identical in both modes.

## Test plan
- Single request: `req`=4'b0100, `req_data[23:16]`=8'hA5 →
  - `ack`=4'b0100 for one cycle, `grant_id`=2, `data`=8'hA5.
  - `send` is one-cycle high on the next cycle.
  - `busy` stays high for 13 cycles.
- Round-robin, all requesting: `req`=4'b1111 held, each requester dropping its bit on its `ack` →
  - Grants in order 0,1,2,3.
  - `send` pulses exactly 14 cycles apart.
  - `data` matches each requester's byte.
- Wrap-around: grant 3 with `rr` wrapping to 0, then `req`=4'b1001 → requester 0 is granted before requester 3.
- Held request: `req[1]`=1 continuously, others 0 → requester 1 is granted every 14 cycles with no gap. Then raise `req[2]` → 2 is served before 1's next frame.
- Reset mid-WAIT: `rst`=0 on the fifth cycle of WAIT →
  - Next cycle: `busy`=0, `send`=0, `data`=0, `grant_id`=0.
  - A pending `req`=4'b0001 after `rst`=1 is granted 1 cycle after release.
- With `TX_ARB_FIXED_PRIO_EN`: `req`=4'b1010 held → requester 1 is granted every frame and requester 3 starves until `req[1]` drops.
